// File: rtl/cpu_bus_pkg.sv
// Shared definitions for requesters on the execution-unit memory bus:
// owner encoding, default arbitration limits and bus widths.
package cpu_bus_pkg;

    typedef enum logic {
        CPU_OWN = 1'b0,
        DMA_OWN = 1'b1
    } owner_e;

    localparam int MAX_WAIT_DEF  = 8;
    localparam int BURST_MAX_DEF = 4;
    localparam int BUS_DATA_W    = 16;
    localparam int BUS_ADDR_W    = 16;

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_sched.sv
// Ownership scheduler for the shared memory port: counts how long a DMA
// request has waited under CPU ownership and how long the DMA burst has run.
module arb_sched
    import cpu_bus_pkg::*;
#(
    parameter int MAX_WAIT  = MAX_WAIT_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   dma_req,
    output owner_e owner
);

    localparam int WAIT_W  = cnt_w(MAX_WAIT);
    localparam int BURST_W = cnt_w(BURST_MAX);
    localparam logic [WAIT_W-1:0]  WAIT_LIM  = WAIT_W'(MAX_WAIT);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(BURST_MAX);

    owner_e             owner_q;
    owner_e             owner_d;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WAIT_W-1:0]  wait_cnt_d;
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] burst_cnt_d;

    function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] cnt);
        return (cnt == WAIT_LIM) ? cnt : cnt + 1'b1;
    endfunction

    function automatic logic [BURST_W-1:0] sat_inc_burst(input logic [BURST_W-1:0] cnt);
        return (cnt == BURST_LIM) ? cnt : cnt + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= CPU_OWN;
            wait_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            owner_q   <= owner_d;
            wait_cnt  <= wait_cnt_d;
            burst_cnt <= burst_cnt_d;
        end
    end

    // Counters restart from zero on every ownership change, which is what
    // guarantees the CPU MAX_WAIT+1 cycles between consecutive bursts.
    always_comb begin
        owner_d     = owner_q;
        wait_cnt_d  = wait_cnt;
        burst_cnt_d = burst_cnt;
        if (owner_q == CPU_OWN) begin
            burst_cnt_d = '0;
            if (!dma_req) begin
                wait_cnt_d = '0;
            end else if (wait_cnt == WAIT_LIM) begin
                owner_d     = DMA_OWN;
                wait_cnt_d  = '0;
                burst_cnt_d = BURST_W'(1);
            end else begin
                wait_cnt_d = sat_inc_wait(wait_cnt);
            end
        end else begin
            wait_cnt_d = '0;
            if (!dma_req || burst_cnt == BURST_LIM) begin
                owner_d     = CPU_OWN;
                burst_cnt_d = '0;
            end else begin
                burst_cnt_d = sat_inc_burst(burst_cnt);
            end
        end
    end

    assign owner = owner_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: the execution unit owns the port by default,
// a DMA requester is granted bounded bursts after a bounded wait.
module mem_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int MAX_WAIT  = MAX_WAIT_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF,
    parameter int DATA_W    = BUS_DATA_W,
    parameter int ADDR_W    = BUS_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_byte_enable,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_byte_enable,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_we,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_byte_enable,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    owner_e            owner;
    owner_e            last_owner;
    logic              last_we;
    logic              vld_p1;
    logic              cpu_rd_p1;
    logic [DATA_W-1:0] cpu_rdata_q;

    arb_sched #(
        .MAX_WAIT  (MAX_WAIT),
        .BURST_MAX (BURST_MAX)
    ) u_sched (
        .clk     (clk),
        .rst_n   (rst_n),
        .dma_req (dma_req),
        .owner   (owner)
    );

    assign dma_gnt   = (owner == DMA_OWN);
    assign cpu_stall = dma_gnt;

    // p0: owner's request goes straight to the port; a granted DMA cycle
    // without a request becomes a dead cycle with writes suppressed.
    always_comb begin
        mem_addr        = cpu_addr;
        mem_byte_enable = cpu_byte_enable;
        mem_wdata       = cpu_wdata;
        mem_we          = cpu_we;
        if (dma_gnt) begin
            mem_addr        = dma_addr;
            mem_byte_enable = dma_byte_enable;
            mem_wdata       = dma_wdata;
            mem_we          = dma_req & dma_we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner  <= CPU_OWN;
            last_we     <= 1'b1;
            vld_p1      <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            last_owner <= owner;
            last_we    <= mem_we;
            vld_p1     <= dma_gnt & dma_req & ~dma_we;
            if (cpu_rd_p1) begin
                cpu_rdata_q <= mem_rdata;
            end
        end
    end

    // p1: mem_rdata belongs to whoever read in the previous cycle; the CPU
    // copy is held so it survives a stall that follows the read.
    assign cpu_rd_p1  = (last_owner == CPU_OWN) && !last_we;
    assign cpu_rdata  = cpu_rd_p1 ? mem_rdata : cpu_rdata_q;
    assign dma_rvalid = vld_p1;
    assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the arbitration rules.
module tb_mem_arbiter;

    localparam int MAX_WAIT  = 8;
    localparam int BURST_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_byte_enable, cpu_we, cpu_stall;
    logic        dma_req, dma_byte_enable, dma_we, dma_gnt, dma_rvalid;
    logic [15:0] dma_addr, dma_wdata, dma_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_byte_enable, mem_we;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];

    int n_chk  = 0;
    int n_pass = 0;

    // behavioural model state
    bit          m_dma;
    int          m_streak;
    int          m_used;
    bit          m_prev_cpu_rd;
    bit          m_prev_dma_rd;
    logic [15:0] m_prev_data;
    logic [15:0] m_hold;

    logic        obs_gnt, obs_stall, obs_rvalid, obs_we;
    logic [15:0] obs_rdata, obs_drdata;
    int          rv_count;

    mem_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpu_addr        (cpu_addr),
        .cpu_byte_enable (cpu_byte_enable),
        .cpu_wdata       (cpu_wdata),
        .cpu_we          (cpu_we),
        .cpu_rdata       (cpu_rdata),
        .cpu_stall       (cpu_stall),
        .dma_req         (dma_req),
        .dma_addr        (dma_addr),
        .dma_byte_enable (dma_byte_enable),
        .dma_wdata       (dma_wdata),
        .dma_we          (dma_we),
        .dma_gnt         (dma_gnt),
        .dma_rvalid      (dma_rvalid),
        .dma_rdata       (dma_rdata),
        .mem_addr        (mem_addr),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_we          (mem_we),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    // synchronous memory, one cycle read latency
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] <= 16'(i) ^ 16'hA5C3;
    end
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_dma = 0; m_streak = 0; m_used = 0;
        m_prev_cpu_rd = 0; m_prev_dma_rd = 0;
        m_prev_data = '0; m_hold = '0;
    endtask

    // One clock cycle: inputs already driven at the falling edge.
    task automatic step();
        logic        exp_we;
        logic [15:0] addr, wd;
        bit          cpu_rd, dma_rd;
        #1;
        exp_we = m_dma ? (dma_req & dma_we) : cpu_we;
        addr   = m_dma ? dma_addr : cpu_addr;
        wd     = m_dma ? dma_wdata : cpu_wdata;
        chk("dma_gnt", 16'(dma_gnt), 16'(m_dma));
        chk("cpu_stall", 16'(cpu_stall), 16'(m_dma));
        chk("mem_addr", mem_addr, addr);
        chk("mem_we", 16'(mem_we), 16'(exp_we));
        chk("mem_be", 16'(mem_byte_enable), 16'(m_dma ? dma_byte_enable : cpu_byte_enable));
        if (exp_we) chk("mem_wdata", mem_wdata, wd);
        chk("cpu_rdata", cpu_rdata, m_prev_cpu_rd ? m_prev_data : m_hold);
        chk("dma_rvalid", 16'(dma_rvalid), 16'(m_prev_dma_rd));
        if (m_prev_dma_rd) chk("dma_rdata", dma_rdata, m_prev_data);
        obs_gnt = dma_gnt; obs_stall = cpu_stall; obs_rvalid = dma_rvalid;
        obs_we = mem_we; obs_rdata = cpu_rdata; obs_drdata = dma_rdata;
        @(posedge clk);
        cpu_rd = !m_dma && !cpu_we;
        dma_rd = m_dma && dma_req && !dma_we;
        if (m_prev_cpu_rd) m_hold = m_prev_data;
        m_prev_data = ref_mem[addr];
        if (exp_we) ref_mem[addr] = wd;
        m_prev_cpu_rd = cpu_rd;
        m_prev_dma_rd = dma_rd;
        if (!m_dma) begin
            if (dma_req) begin
                m_streak++;
                if (m_streak == MAX_WAIT + 1) begin
                    m_dma = 1; m_streak = 0; m_used = 0;
                end
            end else begin
                m_streak = 0;
            end
        end else begin
            m_used++;
            if (!dma_req || m_used == BURST_MAX) begin
                m_dma = 0; m_used = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_grant();
        for (int k = 0; k < 40 && !m_dma; k++) step();
        #1;
        chk("grant_reached", 16'(dma_gnt), 16'd1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = 16'(i) ^ 16'hA5C3;
        model_reset();
        rst_n = 1'b0;
        cpu_addr = '0; cpu_byte_enable = 1'b1; cpu_wdata = '0; cpu_we = 1'b0;
        dma_req = 1'b0; dma_addr = '0; dma_byte_enable = 1'b1; dma_wdata = '0; dma_we = 1'b0;
        #2;
        chk("rst_gnt", 16'(dma_gnt), 16'd0);
        chk("rst_stall", 16'(cpu_stall), 16'd0);
        chk("rst_rvalid", 16'(dma_rvalid), 16'd0);
        chk("rst_cpu_rdata", cpu_rdata, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // CPU-only traffic: write a marker, then back-to-back reads
        cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 16'hBEEF; step();
        cpu_we = 1'b0; cpu_addr = 16'h0100; step();
        cpu_addr = 16'h0102; step();
        chk("rd_0100", obs_rdata, 16'hA4C3);
        cpu_addr = 16'h0200; step();
        chk("rd_0102", obs_rdata, 16'hA4C1);
        chk("cpu_only_stall", 16'(obs_stall), 16'd0);

        // continuous DMA request: 9 CPU cycles, 4 DMA cycles, repeating;
        // the CPU read of 0x0200 just before the grant must survive the stall
        for (int i = 0; i < 26; i++) begin
            dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0400 + 16'(i);
            cpu_addr = 16'h0200; cpu_we = 1'b0;
            step();
            chk("gnt_pattern", 16'(obs_gnt), 16'((i % 13) >= 9));
            if (i >= 9 && i <= 13) chk("stall_hold_rdata", obs_rdata, 16'hBEEF);
        end

        // granted DMA write then read of 0x0300 while the CPU tries to write
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0300; dma_wdata = 16'h1234;
        cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 16'hDEAD;
        wait_grant();
        rv_count = 0;
        step();
        rv_count += int'(obs_rvalid);
        dma_we = 1'b0; step();
        rv_count += int'(obs_rvalid);
        dma_req = 1'b0; step();
        rv_count += int'(obs_rvalid);
        chk("dead_mem_we", 16'(obs_we), 16'd0);
        chk("dma_rvalid_pulse", 16'(obs_rvalid), 16'd1);
        chk("dma_rdata_1234", obs_drdata, 16'h1234);
        step();
        rv_count += int'(obs_rvalid);
        chk("back_to_cpu", 16'(obs_gnt), 16'd0);
        chk("rvalid_once", 16'(rv_count), 16'd1);

        // DMA request dropped after a single granted cycle
        cpu_we = 1'b1; cpu_addr = 16'h0310; cpu_wdata = 16'h5555;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0301;
        wait_grant();
        step();
        dma_req = 1'b0; step();
        chk("short_dead_we", 16'(obs_we), 16'd0);
        chk("short_dead_gnt", 16'(obs_gnt), 16'd1);
        step();
        chk("short_return", 16'(obs_gnt), 16'd0);

        // randomized traffic on a small address window
        dma_req = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) dma_req = ~dma_req;
            cpu_addr = 16'h0300 + 16'($urandom_range(0, 15));
            dma_addr = 16'h0300 + 16'($urandom_range(0, 15));
            cpu_we = 1'($urandom_range(0, 1));
            dma_we = 1'($urandom_range(0, 1));
            cpu_wdata = 16'($urandom);
            dma_wdata = 16'($urandom);
            cpu_byte_enable = 1'($urandom_range(0, 1));
            dma_byte_enable = 1'($urandom_range(0, 1));
            step();
        end

        // asynchronous reset in the middle of a DMA read burst
        cpu_we = 1'b0; cpu_byte_enable = 1'b1; dma_byte_enable = 1'b1;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0305;
        wait_grant();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", 16'(dma_gnt), 16'd0);
        chk("async_rst_stall", 16'(cpu_stall), 16'd0);
        chk("async_rst_rvalid", 16'(dma_rvalid), 16'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_cpu_owns", 16'(obs_gnt), 16'd0);
        chk("post_rst_no_rvalid", 16'(obs_rvalid), 16'd0);
        for (int i = 0; i < 14; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: MAX_WAIT, 8, CPU-owned cycles a pending DMA request waits before grant; BURST_MAX, 4, maximum consecutive DMA-owned cycles.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 cpu_addr / cpu_byte_enable / cpu_wdata / cpu_we  in  16/1/16/1  execution-unit memory request, presented every cycle.
REQ-005 cpu_rdata  out  16  read data returned to the execution unit.
REQ-006 cpu_stall  out  1  clock-enable hold for the execution unit; high = unit holds all state and outputs.
REQ-007 dma_req / dma_addr / dma_byte_enable / dma_wdata / dma_we  in  1/16/1/16/1  secondary requester access.
REQ-008 dma_gnt  out  1  DMA owns the memory port this cycle.
REQ-009 dma_rvalid / dma_rdata  out  1/16  DMA read data valid, one cycle after a granted read.
REQ-010 mem_addr / mem_byte_enable / mem_wdata / mem_we  out  16/1/16/1  shared memory port; mem_rdata  in  16.

Function
REQ-011 Owner state SHALL be one registered bit: CPU_OWN or DMA_OWN; dma_gnt = cpu_stall = (owner == DMA_OWN).
REQ-012 Memory outputs SHALL be a combinational mux of the owner's request fields; no added latency on the CPU path.
REQ-013 In DMA_OWN with dma_req low, mem_we SHALL be 0 (dead cycle).
REQ-014 wait_cnt SHALL increment each CPU_OWN cycle with dma_req high, saturate at MAX_WAIT, clear when dma_req is low or on DMA grant.
REQ-015 CPU_OWN -> DMA_OWN SHALL occur at the edge where dma_req is high and wait_cnt == MAX_WAIT.
REQ-016 burst_cnt SHALL count DMA_OWN cycles from 1; DMA_OWN -> CPU_OWN at the edge where dma_req is low or burst_cnt == BURST_MAX.
REQ-017 After any DMA_OWN -> CPU_OWN transition the CPU SHALL own at least MAX_WAIT+1 cycles before the next grant.
REQ-018 Memory read latency is one cycle; a registered last_owner/last_we pair SHALL tag the data on mem_rdata.
REQ-019 cpu_rdata SHALL equal mem_rdata when the previous cycle was a CPU read, else a held register cpu_rdata_q.
REQ-020 cpu_rdata_q SHALL capture mem_rdata in the cycle after every CPU-owned read, so data survives a following stall.
REQ-021 dma_rvalid SHALL pulse 1 cycle after each DMA-owned cycle with dma_req=1 and dma_we=0; dma_rdata = mem_rdata in that cycle.
REQ-022 A CPU write SHALL never occur in a DMA_OWN cycle; a DMA write only in DMA_OWN with dma_req=1.

Reset
REQ-023 On rst_n low, owner SHALL be CPU_OWN, wait_cnt=0, burst_cnt=0, cpu_rdata_q=0, last_owner=CPU, last_we=1, dma_rvalid=0, immediately and asynchronously.
REQ-024 Reset during a DMA burst SHALL abandon it; no dma_rvalid pulse follows reset release.

Structure
REQ-025 Owner encoding and MAX_WAIT/BURST_MAX defaults SHALL live in a shared package cpu_bus_pkg for reuse by future requesters.
REQ-026 The owner/wait/burst logic SHALL be a sub-module arb_sched; mux and read-return tagging stay in mem_arbiter.

Verification
REQ-027 dma_req=0, CPU reads 0x0100 then 0x0102 -> cpu_stall stays 0, cpu_rdata equals memory contents one cycle after each address.
REQ-028 dma_req held high from cycle 0 -> dma_gnt rises after 9 CPU cycles, stays 4 cycles, falls for 9 cycles, repeats.
REQ-029 CPU read 0x0200 (mem=0xBEEF) in the cycle before a grant -> cpu_rdata=0xBEEF throughout the stall and on the first un-stalled cycle.
REQ-030 Granted DMA write 0x1234 to 0x0300, then DMA read 0x0300 -> dma_rvalid pulses once with dma_rdata=0x1234; CPU we ignored in those cycles.
REQ-031 dma_req dropped after one granted cycle -> owner returns to CPU next edge, burst_cnt=1 at exit, mem_we=0 in any dead cycle.
REQ-032 rst_n asserted mid-burst -> dma_gnt and cpu_stall drop without waiting for clk, dma_rvalid=0, CPU owns first cycle after release.
